// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the accumulator CPU controller.
//   - opcode values of the instruction set
//   - controller state encoding
//   - helper that tells whether an opcode waits on the memory handshake
package cpu_ctrl_pkg;

  localparam int unsigned OP_NOP = 32'd0;
  localparam int unsigned OP_LDA = 32'd1;
  localparam int unsigned OP_STA = 32'd2;
  localparam int unsigned OP_ADD = 32'd3;
  localparam int unsigned OP_JMP = 32'd4;
  localparam int unsigned OP_JZ  = 32'd5;
  localparam int unsigned OP_HLT = 32'd6;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  // LDA, ADD and STA are the only EXEC operations that wait for mem_ready.
  function automatic logic is_mem_op(input logic [31:0] opc);
    return (opc == OP_LDA) || (opc == OP_ADD) || (opc == OP_STA);
  endfunction

endpackage

// File: rtl/cpu_controller_p_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for mem_ready and flags a
// timeout on the cycle in which the count reaches WAIT_LIMIT.
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous, active-high
//   clr      in  restart the count (controller changes state)
//   waiting  in  controller is waiting on mem_ready this cycle
//   expired  out this waiting cycle is the WAIT_LIMIT-th one (combinational)
// WAIT_LIMIT = 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic waiting,
  output logic expired
);

  // Count value held during the last permitted waiting cycle.
  localparam logic [CNT_W-1:0] LAST = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

  logic [CNT_W-1:0] cnt;

  // Wait-cycle counter; clear has priority so a state change always restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (waiting && (WAIT_LIMIT > 0)) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // waiting already implies mem_ready=0, so a late mem_ready wins over the limit.
  assign expired = (WAIT_LIMIT > 0) && waiting && (cnt == LAST);

endmodule

// File: rtl/cpu_controller_p.sv
// cpu_controller_p: multi-cycle control unit for the accumulator CPU.
// Sequences FETCH -> DECODE -> EXEC and drives the datapath strobes.
// Ports:
//   clk, reset (sync, active-high)
//   ir [IR_W]     instruction register, opcode in the top OPC_W bits
//   zero          accumulator == 0
//   mem_ready     memory completes current read/write this cycle
//   rd_mem, wr_mem, ld_ac, ld_ir, ld_pc, inc_pc, pass, add : datapath strobes
//   halted        level, controller in HALT
//   illegal       one-cycle pulse on an undefined opcode in DECODE
//   bus_err       sticky, mem_ready timeout seen
import cpu_ctrl_pkg::*;

module cpu_controller_p #(
  parameter int IR_W       = 8,
  parameter int OPC_W      = 3,
  parameter int WAIT_LIMIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] ir,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            rd_mem,
  output logic            wr_mem,
  output logic            ld_ac,
  output logic            ld_ir,
  output logic            ld_pc,
  output logic            inc_pc,
  output logic            pass,
  output logic            add,
  output logic            halted,
  output logic            illegal,
  output logic            bus_err
);

  // At least one counter bit even when the timeout is disabled.
  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [OPC_W-1:0] opc;
  logic [OPC_W-1:0] dec_opc;
  logic             bus_err_r;
  logic             mem_op;
  logic             waiting;
  logic             expired;
  logic             clr;
  logic             unused_ir_bits;

  assign dec_opc        = ir[IR_W-1 -: OPC_W];
  assign unused_ir_bits = ^ir;
  assign mem_op         = is_mem_op(32'(opc));
  assign waiting        = !mem_ready && ((state == FETCH) || ((state == EXEC) && mem_op));
  assign clr            = (state_nxt != state);

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .waiting (waiting),
    .expired (expired)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (mem_ready) begin
          state_nxt = DECODE;
        end else if (expired) begin
          state_nxt = HALT;
        end else begin
          state_nxt = FETCH;
        end
      end
      DECODE: begin
        if (dec_opc == OPC_W'(OP_NOP)) begin
          state_nxt = FETCH;
        end else if (dec_opc == OPC_W'(OP_HLT)) begin
          state_nxt = HALT;
        end else if (dec_opc > OPC_W'(OP_HLT)) begin
          state_nxt = FETCH;   // illegal: behaves as NOP
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!mem_op || mem_ready) begin
          state_nxt = FETCH;
        end else if (expired) begin
          state_nxt = HALT;
        end else begin
          state_nxt = EXEC;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // State, latched opcode and sticky bus error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      opc       <= '0;
      bus_err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        opc <= dec_opc;
      end else begin
        opc <= opc;
      end
      if (expired) begin
        bus_err_r <= 1'b1;
      end else begin
        bus_err_r <= bus_err_r;
      end
    end
  end

  // Output decode; reset forces every output low in the same cycle.
  always_comb begin
    rd_mem  = 1'b0;
    wr_mem  = 1'b0;
    ld_ac   = 1'b0;
    ld_ir   = 1'b0;
    ld_pc   = 1'b0;
    inc_pc  = 1'b0;
    pass    = 1'b0;
    add     = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    if (!reset) begin
      bus_err = bus_err_r;
      case (state)
        FETCH: begin
          rd_mem = 1'b1;
          ld_ir  = mem_ready;
          inc_pc = mem_ready;
        end
        DECODE: begin
          illegal = (dec_opc > OPC_W'(OP_HLT));
        end
        EXEC: begin
          case (opc)
            OPC_W'(OP_LDA): begin
              rd_mem = 1'b1;
              pass   = 1'b1;
              ld_ac  = mem_ready;
            end
            OPC_W'(OP_ADD): begin
              rd_mem = 1'b1;
              add    = 1'b1;
              ld_ac  = mem_ready;
            end
            OPC_W'(OP_STA): wr_mem = 1'b1;
            OPC_W'(OP_JMP): ld_pc  = 1'b1;
            OPC_W'(OP_JZ):  ld_pc  = zero;
            default:        ld_pc  = 1'b0;
          endcase
        end
        HALT:    halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end else begin
      bus_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_controller_p.sv
// Directed testbench for cpu_controller_p: one instance with the default
// timeout and one with WAIT_LIMIT=4, driven by the same inputs.
module tb_cpu_controller_p;

  // Observation vector bit positions (msb first):
  // rd_mem wr_mem ld_ac ld_ir ld_pc inc_pc pass add halted illegal bus_err
  localparam logic [10:0] NONE = 11'h000;
  localparam logic [10:0] RD   = 11'h400;
  localparam logic [10:0] WR   = 11'h200;
  localparam logic [10:0] LDAC = 11'h100;
  localparam logic [10:0] LDIR = 11'h080;
  localparam logic [10:0] LDPC = 11'h040;
  localparam logic [10:0] INC  = 11'h020;
  localparam logic [10:0] PASS = 11'h010;
  localparam logic [10:0] ADD  = 11'h008;
  localparam logic [10:0] HLT  = 11'h004;
  localparam logic [10:0] ILL  = 11'h002;
  localparam logic [10:0] BERR = 11'h001;
  localparam logic [10:0] FET  = RD | LDIR | INC;

  logic       clk;
  logic       reset;
  logic [7:0] ir;
  logic       zero;
  logic       mem_ready;

  logic a_rd, a_wr, a_ldac, a_ldir, a_ldpc, a_inc, a_pass, a_add, a_hlt, a_ill, a_berr;
  logic b_rd, b_wr, b_ldac, b_ldir, b_ldpc, b_inc, b_pass, b_add, b_hlt, b_ill, b_berr;
  logic [10:0] obs_a;
  logic [10:0] obs_b;

  int tests;
  int failed;

  cpu_controller_p dut (
    .clk(clk), .reset(reset), .ir(ir), .zero(zero), .mem_ready(mem_ready),
    .rd_mem(a_rd), .wr_mem(a_wr), .ld_ac(a_ldac), .ld_ir(a_ldir), .ld_pc(a_ldpc),
    .inc_pc(a_inc), .pass(a_pass), .add(a_add), .halted(a_hlt), .illegal(a_ill),
    .bus_err(a_berr)
  );

  cpu_controller_p #(.WAIT_LIMIT(4)) dut4 (
    .clk(clk), .reset(reset), .ir(ir), .zero(zero), .mem_ready(mem_ready),
    .rd_mem(b_rd), .wr_mem(b_wr), .ld_ac(b_ldac), .ld_ir(b_ldir), .ld_pc(b_ldpc),
    .inc_pc(b_inc), .pass(b_pass), .add(b_add), .halted(b_hlt), .illegal(b_ill),
    .bus_err(b_berr)
  );

  assign obs_a = {a_rd, a_wr, a_ldac, a_ldir, a_ldpc, a_inc, a_pass, a_add, a_hlt, a_ill, a_berr};
  assign obs_b = {b_rd, b_wr, b_ldac, b_ldir, b_ldpc, b_inc, b_pass, b_add, b_hlt, b_ill, b_berr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, settle, then let the caller check.
  task automatic step(input logic r, input logic mr, input logic [7:0] i, input logic z);
    @(negedge clk);
    reset     = r;
    mem_ready = mr;
    ir        = i;
    zero      = z;
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    reset     = 1'b1;
    mem_ready = 1'b1;
    ir        = 8'h20;
    zero      = 1'b0;

    // LDA with mem_ready high: 3-cycle instruction
    step(1'b1, 1'b1, 8'h20, 1'b0); chk("reset_a", obs_a, NONE); chk("reset_b", obs_b, NONE);
    step(1'b0, 1'b1, 8'h20, 1'b0); chk("lda_fetch", obs_a, FET);
    step(1'b0, 1'b1, 8'h20, 1'b0); chk("lda_decode", obs_a, NONE);
    step(1'b0, 1'b1, 8'h20, 1'b0); chk("lda_exec", obs_a, RD | PASS | LDAC);
    step(1'b0, 1'b1, 8'h60, 1'b0); chk("lda_back_fetch", obs_a, FET);

    // ADD, mem_ready low for 3 EXEC cycles then high
    step(1'b0, 1'b1, 8'h60, 1'b0); chk("add_decode", obs_a, NONE);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 8'h60, 1'b0); chk("add_wait_a", obs_a, RD | ADD); chk("add_wait_b", obs_b, RD | ADD);
    end
    // 4th wait cycle hits WAIT_LIMIT=4 on dut4 together with mem_ready: no error
    step(1'b0, 1'b1, 8'h60, 1'b0); chk("add_done_a", obs_a, RD | ADD | LDAC); chk("add_done_b", obs_b, RD | ADD | LDAC);

    // JZ with zero=0 then zero=1
    step(1'b0, 1'b1, 8'hA0, 1'b0); chk("jz0_fetch_a", obs_a, FET); chk("ready_wins_b", obs_b, FET);
    step(1'b0, 1'b1, 8'hA0, 1'b0); chk("jz0_decode", obs_a, NONE);
    step(1'b0, 1'b1, 8'hA0, 1'b0); chk("jz0_exec", obs_a, NONE);
    step(1'b0, 1'b1, 8'hA0, 1'b1); chk("jz1_fetch", obs_a, FET);
    step(1'b0, 1'b1, 8'hA0, 1'b1); chk("jz1_decode", obs_a, NONE);
    step(1'b0, 1'b1, 8'hA0, 1'b1); chk("jz1_exec", obs_a, LDPC);
    step(1'b0, 1'b1, 8'hE0, 1'b1); chk("jz1_after", obs_a, FET);

    // Illegal opcode 7: single-cycle pulse, back to FETCH
    step(1'b0, 1'b1, 8'hE0, 1'b0); chk("ill_decode", obs_a, ILL);
    step(1'b0, 1'b1, 8'hC0, 1'b0); chk("ill_fetch", obs_a, FET);

    // HLT: 2 cycles to HALT, then stuck despite mem_ready toggling
    step(1'b0, 1'b1, 8'hC0, 1'b0); chk("hlt_decode", obs_a, NONE);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, k[0], 8'hC0, 1'b0); chk("halt_hold", obs_a, HLT);
    end
    step(1'b1, 1'b1, 8'h80, 1'b0); chk("halt_reset", obs_a, NONE);

    // JMP then NOP
    step(1'b0, 1'b1, 8'h80, 1'b0); chk("jmp_fetch", obs_a, FET);
    step(1'b0, 1'b1, 8'h80, 1'b0); chk("jmp_decode", obs_a, NONE);
    step(1'b0, 1'b1, 8'h80, 1'b0); chk("jmp_exec_a", obs_a, LDPC); chk("jmp_exec_b", obs_b, LDPC);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk("nop_fetch", obs_a, FET);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk("nop_decode", obs_a, NONE);

    // STA with mem_ready stuck low: dut4 times out after 4 wait cycles
    step(1'b0, 1'b1, 8'h40, 1'b0); chk("sta_fetch_a", obs_a, FET); chk("sta_fetch_b", obs_b, FET);
    step(1'b0, 1'b0, 8'h40, 1'b0); chk("sta_decode", obs_b, NONE);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 8'h40, 1'b0); chk("sta_wait_a", obs_a, WR); chk("sta_wait_b", obs_b, WR);
    end
    step(1'b0, 1'b1, 8'h40, 1'b0); chk("sta_done_a", obs_a, WR); chk("timeout_b", obs_b, HLT | BERR);
    step(1'b0, 1'b1, 8'h40, 1'b0); chk("sta_next_a", obs_a, FET); chk("timeout_hold_b", obs_b, HLT | BERR);

    // Reset in the middle of an ADD EXEC
    step(1'b1, 1'b1, 8'h60, 1'b0); chk("rst2_a", obs_a, NONE); chk("rst2_b", obs_b, NONE);
    step(1'b0, 1'b1, 8'h60, 1'b0); chk("add2_fetch", obs_a, FET);
    step(1'b0, 1'b1, 8'h60, 1'b0); chk("add2_decode", obs_a, NONE);
    step(1'b0, 1'b0, 8'h60, 1'b0); chk("add2_exec_a", obs_a, RD | ADD); chk("add2_exec_b", obs_b, RD | ADD);
    step(1'b1, 1'b0, 8'h60, 1'b0); chk("mid_rst_a", obs_a, NONE); chk("mid_rst_b", obs_b, NONE);
    step(1'b0, 1'b0, 8'h60, 1'b0); chk("post_rst_a", obs_a, RD); chk("post_rst_b", obs_b, RD);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
